hdc_classify_seq: RTL and testbench
===================================

// Module: hdc_classify_seq
// PURPOSE
//  Sequencer for the HDC spam/ham classifier datapath. Accepts a message one byte per handshake and tokenizes it.
//  Drives item-memory reads and bundling-accumulator strobes chunk by chunk, then the average/threshold pass.
//  Finally drives the Hamming compare pass and forms the ham/spam decision from the returned per-chunk distances.
//  Sits between the message source and the word-serial encode/compare datapath; holds no hypervector storage itself.
// PARAMETERS
//  MAX_LENGTH  200    max message length in characters (token buffer depth)
//  NUM_CHAR    37     item-memory symbols (0 = other, 1..10 = '0'..'9', 11..36 = 'a'..'z')
//  DIM         10000  hypervector dimension
//  CHUNK       16     dimensions per datapath word; DIM % CHUNK == 0
//  NUM_CHUNKS  DIM/CHUNK (625)  words per hypervector
//  CNT_W       16     width of distance accumulators
// PORTS
//  clk        in   1   clock
//  reset      in   1   synchronous, active-high reset
//  start      in   1   begin classification (sampled in IDLE only)
//  msg_len    in   8   message length, sampled with start; values > MAX_LENGTH are clamped to MAX_LENGTH
//  char_valid in   1   input byte valid
//  char_data  in   8   ASCII byte
//  char_ready out  1   high only in LOAD
//  im_rd_en   out  1   item-memory read strobe
//  im_addr    out  $clog2(NUM_CHAR*NUM_CHUNKS)  token*NUM_CHUNKS + chunk
//  acc_en     out  1   accumulate returned IM word (im_rd_en delayed 1 cycle)
//  acc_first  out  1   with acc_en: first token of this chunk (load, not add)
//  acc_last   out  1   with acc_en: last token of this chunk (add to global sum)
//  chunk_idx  out  $clog2(NUM_CHUNKS)  chunk currently addressed (ACCUM/THRESH/CMP)
//  avg_en     out  1   one-cycle pulse: datapath computes avg = sum/DIM
//  thr_en     out  1   threshold chunk_idx to +1/0/-1 and store to msgVector
//  cmp_en     out  1   compare msgVector[chunk_idx] against ham/spam refs
//  dist_valid in   1   per-chunk distances valid (any latency >= 1, in order)
//  dist_ham   in   5   bit mismatches vs ham ref for one chunk (0..CHUNK)
//  dist_spam  in   5   bit mismatches vs spam ref for one chunk
//  busy       out  1   high in every state except IDLE
//  done       out  1   one-cycle pulse when result updates
//  result     out  2   2'b01 ham, 2'b00 spam, 2'b11 undecided
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (result=2'b00); counters and token buffer pointer cleared. Reset mid-run aborts immediately; no further strobes.
//  IDLE: start && msg_len==0 -> DONE with result=2'b11. start && msg_len!=0 -> LOAD (len latched). start while busy is ignored.
//  LOAD: char_ready=1. Each char_valid&&char_ready: lower-case A-Z, map a-z->11..36, 0-9->1..10, else 0; write tok_buf[wr_ptr++]. After len bytes -> ACCUM.
//  ACCUM: outer loop chunk c=0..NUM_CHUNKS-1, inner token t=0..len-1, one read per cycle, no bubbles. im_addr=tok_buf[t]*NUM_CHUNKS+c.
//   acc_en/acc_first/acc_last/chunk_idx are registered copies, one cycle after the read. After the last read: one drain cycle, then AVG.
//  AVG: avg_en for 1 cycle -> THRESH.
//  THRESH: thr_en=1 for NUM_CHUNKS cycles, chunk_idx 0..NUM_CHUNKS-1 -> CMP.
//  CMP: cmp_en=1 for NUM_CHUNKS cycles with chunk_idx 0..N-1. Concurrently accumulate dist_ham/dist_spam into CNT_W-bit totals on each dist_valid.
//   dist_valid can arrive after issue ends; state waits for exactly NUM_CHUNKS valids. Valids in other states are ignored.
//  DECIDE (1 cycle): ham_tot<spam_tot -> 01; > -> 00; == -> 11. Then DONE.
//  DONE: done=1 for one cycle, result registered and held until next DONE -> IDLE.
//  Totals and counters clear on leaving IDLE. Strobes im_rd_en/acc_en/thr_en/cmp_en/avg_en are mutually exclusive, except the ACCUM overlap of im_rd_en with acc_en.
//  Latency (continuous char_valid, L=len): L + NUM_CHUNKS*L + 1 + 1 + 2*NUM_CHUNKS + dist latency + 2 cycles start->done.
// TESTING (use DIM=64, CHUNK=16 -> NUM_CHUNKS=4)
//  "Ab1", len=3 -> tokens 11,12,2; im_addr 44,48,8,45,49,9,46,50,10,47,51,11; acc_first on 44..47, acc_last on 8..11.
//  len=0 with start -> no strobes; done 2 cycles later, result=11.
//  dist_ham=3, dist_spam=5 per chunk, latency 4 -> result=01; swap -> 00; equal -> 11; exactly 4 dist_valid consumed.
//  char_valid gapped 1-in-3 and start pulsed during LOAD -> tokens correct, second start ignored, char_ready low outside LOAD.
//  reset asserted in ACCUM -> next cycle busy=0, all strobes 0, result=00; new start then runs normally.
//  msg_len=255 -> clamped to 200; exactly 200 bytes accepted, 200*NUM_CHUNKS reads.

Source files
------------

// File: rtl/hdc_classify_seq.sv
// Control sequencer for the HDC spam/ham classifier: tokenizes the message, then steps the
// word-serial encode, average, threshold and compare passes and forms the ham/spam verdict.
module hdc_classify_seq #(
    parameter int MAX_LENGTH = 200,
    parameter int NUM_CHAR   = 37,
    parameter int DIM        = 10000,
    parameter int CHUNK      = 16,
    parameter int NUM_CHUNKS = DIM / CHUNK,
    parameter int CNT_W      = 16,
    localparam int ADDR_W    = $clog2(NUM_CHAR * NUM_CHUNKS),
    localparam int CI_W      = $clog2(NUM_CHUNKS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        msg_len,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              im_rd_en,
    output logic [ADDR_W-1:0] im_addr,
    output logic              acc_en,
    output logic              acc_first,
    output logic              acc_last,
    output logic [CI_W-1:0]   chunk_idx,
    output logic              avg_en,
    output logic              thr_en,
    output logic              cmp_en,
    input  logic              dist_valid,
    input  logic [4:0]        dist_ham,
    input  logic [4:0]        dist_spam,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result
);

    localparam int TOK_W = $clog2(NUM_CHAR);
    localparam int VC_W  = $clog2(NUM_CHUNKS + 1);
    localparam logic [CI_W-1:0]   LAST_CHUNK = CI_W'(NUM_CHUNKS - 1);
    localparam logic [VC_W-1:0]   LAST_VALID = VC_W'(NUM_CHUNKS - 1);
    localparam logic [ADDR_W-1:0] CHUNKS_A   = ADDR_W'(NUM_CHUNKS);
    localparam logic [7:0]        MAX_LEN_B  = 8'(MAX_LENGTH);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ACCUM, S_DRAIN, S_AVG, S_THRESH, S_CMP, S_DECIDE, S_DONE
    } state_t;

    // Case-folded symbol index: a-z -> 11..36, 0-9 -> 1..10, anything else -> 0.
    function automatic logic [TOK_W-1:0] char_to_tok(input logic [7:0] c);
        logic [7:0] t;
        if (c >= 8'h61 && c <= 8'h7a) begin
            t = c - 8'd86;
        end else if (c >= 8'h41 && c <= 8'h5a) begin
            t = c - 8'd54;
        end else if (c >= 8'h30 && c <= 8'h39) begin
            t = c - 8'd47;
        end else begin
            t = 8'd0;
        end
        return TOK_W'(t);
    endfunction

    state_t              state_r;
    logic [7:0]          len_r;
    logic [7:0]          wr_ptr_r;
    logic [7:0]          tok_cnt_r;
    logic [CI_W-1:0]     chunk_cnt_r;
    logic                cmp_issued_r;
    logic [VC_W-1:0]     valid_cnt_r;
    logic [CNT_W-1:0]    ham_tot_r;
    logic [CNT_W-1:0]    spam_tot_r;
    logic [1:0]          verdict_r;
    logic                rd_first_r;
    logic                rd_last_r;
    logic [CI_W-1:0]     rd_chunk_r;
    logic                char_ready_r;
    logic                im_rd_en_r;
    logic [ADDR_W-1:0]   im_addr_r;
    logic                acc_en_r;
    logic                acc_first_r;
    logic                acc_last_r;
    logic [CI_W-1:0]     chunk_idx_r;
    logic                avg_en_r;
    logic                thr_en_r;
    logic                cmp_en_r;
    logic                busy_r;
    logic                done_r;
    logic [1:0]          result_r;

    logic [TOK_W-1:0]    tok_buf [MAX_LENGTH];
    logic                load_fire_s;
    logic [TOK_W-1:0]    rd_tok_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [7:0]          len_in_s;

    assign load_fire_s = (state_r == S_LOAD) && char_valid && char_ready_r;
    assign rd_tok_s    = tok_buf[tok_cnt_r];
    assign addr_s      = ADDR_W'(rd_tok_s) * CHUNKS_A + ADDR_W'(chunk_cnt_r);
    assign len_in_s    = (msg_len > MAX_LEN_B) ? MAX_LEN_B : msg_len;

    // Token buffer write port; contents are only meaningful up to len_r.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            tok_buf[wr_ptr_r] <= char_to_tok(char_data);
        end
    end

    // Main sequencer: state, loop counters, distance totals and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            len_r        <= 8'd0;
            wr_ptr_r     <= 8'd0;
            tok_cnt_r    <= 8'd0;
            chunk_cnt_r  <= '0;
            cmp_issued_r <= 1'b0;
            valid_cnt_r  <= '0;
            ham_tot_r    <= '0;
            spam_tot_r   <= '0;
            verdict_r    <= 2'b00;
            rd_first_r   <= 1'b0;
            rd_last_r    <= 1'b0;
            rd_chunk_r   <= '0;
            char_ready_r <= 1'b0;
            im_rd_en_r   <= 1'b0;
            im_addr_r    <= '0;
            acc_en_r     <= 1'b0;
            acc_first_r  <= 1'b0;
            acc_last_r   <= 1'b0;
            chunk_idx_r  <= '0;
            avg_en_r     <= 1'b0;
            thr_en_r     <= 1'b0;
            cmp_en_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            result_r     <= 2'b00;
        end else begin
            // Strobes default low; the accumulate side trails the read side by one cycle.
            im_rd_en_r   <= 1'b0;
            im_addr_r    <= '0;
            rd_first_r   <= 1'b0;
            rd_last_r    <= 1'b0;
            rd_chunk_r   <= '0;
            avg_en_r     <= 1'b0;
            thr_en_r     <= 1'b0;
            cmp_en_r     <= 1'b0;
            done_r       <= 1'b0;
            char_ready_r <= 1'b0;
            acc_en_r     <= im_rd_en_r;
            acc_first_r  <= rd_first_r;
            acc_last_r   <= rd_last_r;
            chunk_idx_r  <= rd_chunk_r;

            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy_r       <= 1'b1;
                        len_r        <= len_in_s;
                        wr_ptr_r     <= 8'd0;
                        tok_cnt_r    <= 8'd0;
                        chunk_cnt_r  <= '0;
                        cmp_issued_r <= 1'b0;
                        valid_cnt_r  <= '0;
                        ham_tot_r    <= '0;
                        spam_tot_r   <= '0;
                        if (msg_len == 8'd0) begin
                            verdict_r <= 2'b11;
                            state_r   <= S_DONE;
                        end else begin
                            char_ready_r <= 1'b1;
                            state_r      <= S_LOAD;
                        end
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    char_ready_r <= 1'b1;
                    if (load_fire_s) begin
                        wr_ptr_r <= wr_ptr_r + 8'd1;
                        if (wr_ptr_r == len_r - 8'd1) begin
                            char_ready_r <= 1'b0;
                            state_r      <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    im_rd_en_r <= 1'b1;
                    im_addr_r  <= addr_s;
                    rd_first_r <= (tok_cnt_r == 8'd0);
                    rd_last_r  <= (tok_cnt_r == len_r - 8'd1);
                    rd_chunk_r <= chunk_cnt_r;
                    if (tok_cnt_r == len_r - 8'd1) begin
                        tok_cnt_r <= 8'd0;
                        if (chunk_cnt_r == LAST_CHUNK) begin
                            chunk_cnt_r <= '0;
                            state_r     <= S_DRAIN;
                        end else begin
                            chunk_cnt_r <= chunk_cnt_r + CI_W'(1);
                        end
                    end else begin
                        tok_cnt_r <= tok_cnt_r + 8'd1;
                    end
                end
                S_DRAIN: begin
                    state_r <= S_AVG;
                end
                S_AVG: begin
                    avg_en_r    <= 1'b1;
                    chunk_cnt_r <= '0;
                    state_r     <= S_THRESH;
                end
                S_THRESH: begin
                    thr_en_r    <= 1'b1;
                    chunk_idx_r <= chunk_cnt_r;
                    if (chunk_cnt_r == LAST_CHUNK) begin
                        chunk_cnt_r <= '0;
                        state_r     <= S_CMP;
                    end else begin
                        chunk_cnt_r <= chunk_cnt_r + CI_W'(1);
                    end
                end
                S_CMP: begin
                    // Issue runs ahead; the state is held until every distance has come back.
                    if (!cmp_issued_r) begin
                        cmp_en_r    <= 1'b1;
                        chunk_idx_r <= chunk_cnt_r;
                        if (chunk_cnt_r == LAST_CHUNK) begin
                            cmp_issued_r <= 1'b1;
                            chunk_cnt_r  <= '0;
                        end else begin
                            chunk_cnt_r <= chunk_cnt_r + CI_W'(1);
                        end
                    end
                    if (dist_valid) begin
                        ham_tot_r   <= ham_tot_r + CNT_W'(dist_ham);
                        spam_tot_r  <= spam_tot_r + CNT_W'(dist_spam);
                        valid_cnt_r <= valid_cnt_r + VC_W'(1);
                        if (valid_cnt_r == LAST_VALID) begin
                            state_r <= S_DECIDE;
                        end
                    end
                end
                S_DECIDE: begin
                    if (ham_tot_r < spam_tot_r) begin
                        verdict_r <= 2'b01;
                    end else if (ham_tot_r > spam_tot_r) begin
                        verdict_r <= 2'b00;
                    end else begin
                        verdict_r <= 2'b11;
                    end
                    state_r <= S_DONE;
                end
                S_DONE: begin
                    done_r   <= 1'b1;
                    result_r <= verdict_r;
                    busy_r   <= 1'b0;
                    state_r  <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign char_ready = char_ready_r;
    assign im_rd_en   = im_rd_en_r;
    assign im_addr    = im_addr_r;
    assign acc_en     = acc_en_r;
    assign acc_first  = acc_first_r;
    assign acc_last   = acc_last_r;
    assign chunk_idx  = chunk_idx_r;
    assign avg_en     = avg_en_r;
    assign thr_en     = thr_en_r;
    assign cmp_en     = cmp_en_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign result     = result_r;

endmodule

// File: tb/tb_hdc_classify_seq.sv
// Directed bench for hdc_classify_seq with a 64-dimension, 4-chunk configuration and a
// fixed-latency distance responder.
module tb_hdc_classify_seq;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset, start, char_valid, char_ready;
    logic [7:0] msg_len, char_data;
    logic       im_rd_en, acc_en, acc_first, acc_last, avg_en, thr_en, cmp_en;
    logic [7:0] im_addr;
    logic [1:0] chunk_idx;
    logic       dist_valid = 1'b0;
    logic [4:0] dist_ham = 5'd0, dist_spam = 5'd0;
    logic       busy, done;
    logic [1:0] result;

    hdc_classify_seq #(.DIM(64), .CHUNK(16)) dut (
        .clk(clk), .reset(reset), .start(start), .msg_len(msg_len),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .im_rd_en(im_rd_en), .im_addr(im_addr), .acc_en(acc_en), .acc_first(acc_first),
        .acc_last(acc_last), .chunk_idx(chunk_idx), .avg_en(avg_en), .thr_en(thr_en),
        .cmp_en(cmp_en), .dist_valid(dist_valid), .dist_ham(dist_ham), .dist_spam(dist_spam),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, hs_timeouts = 0;
    int n_rd = 0, n_acc = 0, n_avg = 0, n_thr = 0, n_cmp = 0, n_done = 0, n_excl = 0, n_crdy = 0;
    int rd_q[$], af_q[$], al_q[$], ac_q[$];
    logic [4:0] cur_dh = 5'd0, cur_ds = 5'd0;
    bit stray = 1'b0;
    bit [LAT-1:0] pipe = '0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: strobe counts, read/accumulate logs, exclusivity and char_ready sanity.
    always @(negedge clk) begin
        int nstb;
        if (im_rd_en) begin n_rd++; rd_q.push_back(int'(im_addr)); end
        if (acc_en) begin
            n_acc++;
            af_q.push_back(int'(acc_first));
            al_q.push_back(int'(acc_last));
            ac_q.push_back(int'(chunk_idx));
        end
        if (avg_en) n_avg++;
        if (thr_en) n_thr++;
        if (cmp_en) n_cmp++;
        if (done) n_done++;
        nstb = int'(im_rd_en | acc_en) + int'(avg_en) + int'(thr_en) + int'(cmp_en);
        if (nstb > 1) n_excl++;
        if (char_ready && (im_rd_en || acc_en || avg_en || thr_en || cmp_en || !busy)) n_crdy++;
    end

    // Distance responder: returns one distance pair LAT cycles after each cmp_en.
    always @(negedge clk) begin
        pipe = {pipe[LAT-2:0], cmp_en};
        dist_valid = pipe[LAT-1] | stray;
        dist_ham   = stray ? 5'd16 : cur_dh;
        dist_spam  = stray ? 5'd0  : cur_ds;
    end

    typedef struct {
        int         len;
        logic [63:0] text;
        int         nbytes;
        int         gap;
        logic [4:0] dh;
        logic [4:0] ds;
        bit         mid;
        bit         gen;
        logic [1:0] exp_res;
        int         exp_reads;
        int         toks[4];
    } vec_t;

    vec_t vecs[6];

    task automatic send_start(input logic [7:0] len);
        @(negedge clk);
        start = 1'b1; msg_len = len;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [63:0] text, input int nbytes, input int gap,
                        input bit mid, input bit gen);
        logic [7:0] b;
        int k;
        for (int i = 0; i < nbytes; i++) begin
            repeat (gap) @(negedge clk);
            if (mid && i == 1) begin
                start = 1'b1; msg_len = 8'd2; stray = 1'b1;
                @(negedge clk);
                @(negedge clk);
                start = 1'b0; stray = 1'b0;
            end
            if (gen) b = 8'h61 + 8'(i % 26);
            else     b = text[8*i +: 8];
            char_valid = 1'b1; char_data = b; k = 0;
            while (!char_ready && k < 50) begin @(negedge clk); k++; end
            if (k >= 50) hs_timeouts++;
            @(negedge clk);
            char_valid = 1'b0;
        end
        check("ready_low_after_load", int'(char_ready), 0);
    endtask

    task automatic wait_done(output bit got);
        int k = 0;
        while (!done && k < 4000) begin @(negedge clk); k++; end
        got = done;
    endtask

    initial begin
        bit got;
        int k, b_rd, b_acc, b_avg, b_thr, b_cmp, b_all, qb, ab, mism, c, t, n;

        vecs[0] = '{len:3, text:64'h316241, nbytes:3, gap:0, dh:5'd3, ds:5'd5, mid:1'b0,
                    gen:1'b0, exp_res:2'b01, exp_reads:12, toks:'{11, 12, 2, 0}};
        vecs[1] = '{len:3, text:64'h316241, nbytes:3, gap:0, dh:5'd5, ds:5'd3, mid:1'b0,
                    gen:1'b0, exp_res:2'b00, exp_reads:12, toks:'{11, 12, 2, 0}};
        vecs[2] = '{len:3, text:64'h316241, nbytes:3, gap:0, dh:5'd4, ds:5'd4, mid:1'b0,
                    gen:1'b0, exp_res:2'b11, exp_reads:12, toks:'{11, 12, 2, 0}};
        vecs[3] = '{len:1, text:64'h61, nbytes:1, gap:0, dh:5'd16, ds:5'd0, mid:1'b0,
                    gen:1'b0, exp_res:2'b00, exp_reads:4, toks:'{11, 0, 0, 0}};
        vecs[4] = '{len:4, text:64'h3F78395A, nbytes:4, gap:2, dh:5'd0, ds:5'd1, mid:1'b1,
                    gen:1'b0, exp_res:2'b01, exp_reads:16, toks:'{36, 10, 34, 0}};
        vecs[5] = '{len:255, text:64'h0, nbytes:200, gap:0, dh:5'd5, ds:5'd3, mid:1'b0,
                    gen:1'b1, exp_res:2'b00, exp_reads:800, toks:'{0, 0, 0, 0}};

        reset = 1'b1; start = 1'b0; msg_len = 8'd0; char_valid = 1'b0; char_data = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_outputs", int'({busy, done, result, char_ready, im_rd_en, acc_en,
                                     acc_first, acc_last, avg_en, thr_en, cmp_en}), 0);

        // Empty message: straight to DONE with an undecided verdict, no strobes.
        b_all = n_rd + n_acc + n_avg + n_thr + n_cmp;
        @(negedge clk);
        start = 1'b1; msg_len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_busy", int'(busy), 1);
        check("len0_done_early", int'(done), 0);
        @(negedge clk);
        check("len0_done", int'(done), 1);
        check("len0_result", int'(result), 3);
        @(negedge clk);
        check("len0_done_pulse", int'(done), 0);
        check("len0_no_strobes", n_rd + n_acc + n_avg + n_thr + n_cmp - b_all, 0);

        // Reset in the middle of ACCUM aborts everything.
        send_start(8'd3);
        feed(64'h316241, 3, 0, 1'b0, 1'b0);
        k = 0;
        while (!im_rd_en && k < 50) begin @(negedge clk); k++; end
        check("accum_reached", int'(im_rd_en), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_reset_outputs", int'({busy, done, result, char_ready, im_rd_en, acc_en,
                                            avg_en, thr_en, cmp_en}), 0);
        reset = 1'b0;
        b_all = n_rd + n_acc + n_avg + n_thr + n_cmp + n_done;
        repeat (20) @(negedge clk);
        check("post_reset_quiet", n_rd + n_acc + n_avg + n_thr + n_cmp + n_done - b_all, 0);

        for (int r = 0; r < 6; r++) begin
            b_rd = n_rd; b_acc = n_acc; b_avg = n_avg; b_thr = n_thr; b_cmp = n_cmp;
            qb = rd_q.size(); ab = af_q.size();
            cur_dh = vecs[r].dh; cur_ds = vecs[r].ds;
            send_start(8'(vecs[r].len));
            feed(vecs[r].text, vecs[r].nbytes, vecs[r].gap, vecs[r].mid, vecs[r].gen);
            wait_done(got);
            check($sformatf("r%0d_done", r), int'(got), 1);
            check($sformatf("r%0d_result", r), int'(result), int'(vecs[r].exp_res));
            check($sformatf("r%0d_reads", r), n_rd - b_rd, vecs[r].exp_reads);
            check($sformatf("r%0d_accs", r), n_acc - b_acc, vecs[r].exp_reads);
            check($sformatf("r%0d_avg", r), n_avg - b_avg, 1);
            check($sformatf("r%0d_thr", r), n_thr - b_thr, 4);
            check($sformatf("r%0d_cmp", r), n_cmp - b_cmp, 4);
            if (vecs[r].len <= 4) begin
                n = vecs[r].exp_reads;
                mism = 0;
                if (rd_q.size() < qb + n || af_q.size() < ab + n) begin
                    mism = n;
                end else begin
                    for (int j = 0; j < n; j++) begin
                        c = j / vecs[r].len;
                        t = j % vecs[r].len;
                        if (rd_q[qb + j] != vecs[r].toks[t] * 4 + c) mism++;
                        if (af_q[ab + j] != int'(t == 0)) mism++;
                        if (al_q[ab + j] != int'(t == vecs[r].len - 1)) mism++;
                        if (ac_q[ab + j] != c) mism++;
                    end
                end
                check($sformatf("r%0d_addr_flags", r), mism, 0);
            end
            @(negedge clk);
        end

        check("handshake_timeouts", hs_timeouts, 0);
        check("strobe_exclusive", n_excl, 0);
        check("char_ready_outside_load", n_crdy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
